// File: rtl/uart_rx_buffer_ctrl_if.sv
// Handshake bundle between uart_rx, the receive buffer controller and the
// word consumer.
//   rx_data / rx_ready   : word from uart_rx, strobed for one cycle
//   rx_can_receive       : throttle back to uart_rx (can_receive_next_word)
//   out_data / out_valid : FIFO head, first-word-fall-through
//   out_ready            : consumer accepts the head word this cycle
// Modports: slave is the buffer controller's view, master is the view of the
// environment that feeds and drains it.
interface uart_rx_buffer_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] rx_data;
    logic             rx_ready;
    logic             rx_can_receive;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  rx_data,
        input  rx_ready,
        output rx_can_receive,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport master (
        output rx_data,
        output rx_ready,
        input  rx_can_receive,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_buffer_ctrl.sv
// Receive-side buffer controller: captures words from uart_rx into a circular
// FIFO, throttles the receiver with hysteresis, counts dropped words and
// presents the head word on a first-word-fall-through valid/ready port.
// Ports:
//   clock, resetn   : system clock (rising edge), async active-low reset
//   bus (slave)     : rx_data/rx_ready/rx_can_receive, out_data/out_valid/out_ready
//   count           : current occupancy 0..DEPTH
//   overrun         : sticky flag, set when a word is dropped on a full FIFO
//   overrun_count   : dropped-word count, saturating
//   clear_overrun   : clears overrun and overrun_count (wins over a new overrun)
//   flush           : synchronous empty; same-cycle push/pop/overrun ignored
//
// Flow-control states:
//   state     | meaning
//   ST_ACCEPT | rx_can_receive=1, receiver may start new words
//   ST_HOLD   | rx_can_receive=0, FIFO nearly full, waiting to drain to LOW_WATER
module uart_rx_buffer_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int LOW_WATER = DEPTH / 2,
    parameter int OVF_W     = 8
) (
    input  logic                     clock,
    input  logic                     resetn,
    uart_rx_buffer_ctrl_if.slave     bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic [OVF_W-1:0]         overrun_count,
    input  logic                     clear_overrun,
    input  logic                     flush
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] HOLD_CNT  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LOW_CNT   = CW'(LOW_WATER);

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_HOLD   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overrun_q, overrun_d;
    logic [OVF_W-1:0]  ovf_cnt_q, ovf_cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    logic push, pop, drop;
    logic not_empty;

    assign not_empty = (count_q != '0);

    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        if (!flush) begin
            pop  = not_empty && bus.out_ready;
            // A pop in the same cycle frees the slot the incoming word needs.
            push = bus.rx_ready && ((count_q != FULL_CNT) || pop);
            drop = bus.rx_ready && (count_q == FULL_CNT) && !pop;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.rx_data;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Decisions use next occupancy so rx_can_receive changes on the same edge
    // that crosses the threshold. HOLD engages one slot early so a word
    // uart_rx has already started still has somewhere to land.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_ACCEPT;
        end else begin
            case (state_q)
                ST_ACCEPT: if (count_d >= HOLD_CNT) state_d = ST_HOLD;
                ST_HOLD:   if (count_d <= LOW_CNT)  state_d = ST_ACCEPT;
                default:   state_d = ST_ACCEPT;
            endcase
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        ovf_cnt_d = ovf_cnt_q;
        if (clear_overrun) begin
            overrun_d = 1'b0;
            ovf_cnt_d = '0;
        end else if (drop) begin
            overrun_d = 1'b1;
            if (!(&ovf_cnt_q)) ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_ACCEPT;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            ovf_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            ovf_cnt_q <= ovf_cnt_d;
            mem_q     <= mem_d;
        end
    end

    // Head word is gated so out_data reads zero whenever the FIFO is empty.
    assign bus.out_data       = not_empty ? mem_q[rd_ptr_q] : '0;
    assign bus.out_valid      = not_empty;
    assign bus.rx_can_receive = (state_q == ST_ACCEPT);
    assign count              = count_q;
    assign overrun            = overrun_q;
    assign overrun_count      = ovf_cnt_q;
endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
module tb_uart_rx_buffer_ctrl;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] count;
    logic       overrun;
    logic [7:0] overrun_count;
    logic       clear_overrun = 1'b0;
    logic       flush = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [7:0] q[$];
    logic [7:0] got;

    uart_rx_buffer_ctrl_if #(.WIDTH(8)) bus ();

    uart_rx_buffer_ctrl #(.WIDTH(8), .DEPTH(16), .LOW_WATER(8), .OVF_W(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .bus           (bus),
        .count         (count),
        .overrun       (overrun),
        .overrun_count (overrun_count),
        .clear_overrun (clear_overrun),
        .flush         (flush)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        bus.rx_data  = w;
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
    endtask

    task automatic pop_word(output logic [7:0] w);
        w = bus.out_data;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.rx_data   = '0;
        bus.rx_ready  = 1'b0;
        bus.out_ready = 1'b0;
        #12 resetn = 1'b1;
        tick();

        // 1: reset values and single-word latency
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_canrx", 32'(bus.rx_can_receive), 1);
        chk("rst_ovf", 32'(overrun), 0);
        chk("rst_ovfcnt", 32'(overrun_count), 0);
        push_word(8'hA5);
        chk("t1_valid", 32'(bus.out_valid), 1);
        chk("t1_data", 32'(bus.out_data), 32'hA5);
        chk("t1_count", 32'(count), 1);
        pop_word(got);
        chk("t1_popdata", 32'(got), 32'hA5);
        chk("t1_valid0", 32'(bus.out_valid), 0);
        chk("t1_count0", 32'(count), 0);

        // 2: throttle hysteresis
        for (int i = 0; i < 15; i++) begin
            push_word(8'h10 + 8'(i));
            if (i == 13) chk("t2_canrx_14", 32'(bus.rx_can_receive), 1);
        end
        chk("t2_canrx_15", 32'(bus.rx_can_receive), 0);
        chk("t2_count15", 32'(count), 15);
        for (int i = 0; i < 15; i++) begin
            pop_word(got);
            chk("t2_order", 32'(got), 32'(8'h10 + 8'(i)));
            if (i == 5) chk("t2_canrx_9", 32'(bus.rx_can_receive), 0);
            if (i == 6) begin
                chk("t2_canrx_8", 32'(bus.rx_can_receive), 1);
                chk("t2_count8", 32'(count), 8);
            end
        end
        chk("t2_count0", 32'(count), 0);

        // 3: overrun and clear priority
        for (int i = 0; i < 16; i++) push_word(8'h40 + 8'(i));
        chk("t3_count16", 32'(count), 16);
        chk("t3_ovf_pre", 32'(overrun), 0);
        push_word(8'h3C);
        chk("t3_ovf", 32'(overrun), 1);
        chk("t3_ovfcnt1", 32'(overrun_count), 1);
        chk("t3_count", 32'(count), 16);
        push_word(8'h3D);
        chk("t3_ovfcnt2", 32'(overrun_count), 2);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("t3_clr_ovf", 32'(overrun), 0);
        chk("t3_clr_cnt", 32'(overrun_count), 0);
        clear_overrun = 1'b1;
        push_word(8'h3E);
        clear_overrun = 1'b0;
        chk("t3_prio_ovf", 32'(overrun), 0);
        chk("t3_prio_cnt", 32'(overrun_count), 0);
        for (int i = 0; i < 16; i++) begin
            pop_word(got);
            chk("t3_contents", 32'(got), 32'(8'h40 + 8'(i)));
        end
        chk("t3_empty", 32'(bus.out_valid), 0);

        // 4: full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push_word(8'h60 + 8'(i));
        got = bus.out_data;
        bus.rx_data   = 8'h99;
        bus.rx_ready  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.rx_ready  = 1'b0;
        bus.out_ready = 1'b0;
        chk("t4_head", 32'(got), 32'h60);
        chk("t4_count", 32'(count), 16);
        chk("t4_noovf", 32'(overrun), 0);
        for (int i = 1; i < 16; i++) begin
            pop_word(got);
            chk("t4_order", 32'(got), 32'(8'h60 + 8'(i)));
        end
        pop_word(got);
        chk("t4_last", 32'(got), 32'h99);
        chk("t4_count0", 32'(count), 0);

        // 5: wrap with random gaps, two words in flight
        q.delete();
        push_word(8'hC0);
        q.push_back(8'hC0);
        for (int i = 0; i < 40; i++) begin
            push_word(8'(i * 7 + 3));
            q.push_back(8'(i * 7 + 3));
            repeat ($urandom_range(0, 2)) tick();
            pop_word(got);
            chk("t5_wrap", 32'(got), 32'(q.pop_front()));
            repeat ($urandom_range(0, 2)) tick();
        end
        chk("t5_count", 32'(count), 1);
        pop_word(got);
        chk("t5_tail", 32'(got), 32'(q.pop_front()));

        // 6: flush from HOLD with count=10 and both strobes high
        for (int i = 0; i < 15; i++) push_word(8'(i));
        for (int i = 0; i < 5; i++) pop_word(got);
        chk("t6_count10", 32'(count), 10);
        chk("t6_hold", 32'(bus.rx_can_receive), 0);
        flush = 1'b1;
        bus.rx_ready  = 1'b1;
        bus.rx_data   = 8'hEE;
        bus.out_ready = 1'b1;
        tick();
        flush = 1'b0;
        bus.rx_ready  = 1'b0;
        bus.out_ready = 1'b0;
        chk("t6_count0", 32'(count), 0);
        chk("t6_valid", 32'(bus.out_valid), 0);
        chk("t6_accept", 32'(bus.rx_can_receive), 1);
        chk("t6_ovf", 32'(overrun), 0);
        push_word(8'h77);
        chk("t6_after", 32'(bus.out_data), 32'h77);

        // async reset mid-stream
        push_word(8'h78);
        for (int i = 0; i < 14; i++) push_word(8'h80 + 8'(i));
        chk("t6_hold2", 32'(bus.rx_can_receive), 0);
        #2 resetn = 1'b0;
        #1;
        chk("rst2_count", 32'(count), 0);
        chk("rst2_valid", 32'(bus.out_valid), 0);
        chk("rst2_data", 32'(bus.out_data), 0);
        chk("rst2_canrx", 32'(bus.rx_can_receive), 1);
        #10 resetn = 1'b1;
        tick();
        chk("rst2_hold_cnt", 32'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
